// File: rtl/mem_issue_sequencer_pkg.sv
// Shared definitions for the load/store issue sequencer.
// Contents: sequencer FSM encodings, op encodings, the idle label value and
// the latency counter width and preload helper.
package mem_issue_sequencer_pkg;

    // Latency counter width; covers ACC_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

    // Sequencer FSM encodings.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } seq_state_e;

    // Queue head op encodings.
    localparam logic OP_LOAD  = 1'b1;
    localparam logic OP_STORE = 1'b0;

    // Queue label constants; LABEL_NONE is what the CDB tag shows when idle.
    localparam int unsigned LABEL_W_DEF = 4;
    localparam logic [LABEL_W_DEF-1:0] LABEL_NONE = '0;

    // Counter preload so that the last access cycle is the one where count == 0.
    function automatic logic [CNT_W-1:0] acc_preload(input int unsigned acc_cycles);
        return CNT_W'(acc_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag, for multi-cycle unit sequencing.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         load load_val_i (has priority over dec_i)
//   load_val_i     preload value
//   dec_i          decrement by one; saturates at zero
//   zero_o         count register is zero
module mem_latency_counter
    import mem_issue_sequencer_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_issue_sequencer.sv
// Sequences the load/store queue head into the multi-cycle data memory and
// arbitrates load results onto the CDB.
// Ports:
//   clk, nRST                    clock, asynchronous active-low reset
//   require, opIn                head valid/ready, head op (1 = load)
//   addrBase, addrOff            address operands (summed, carry dropped)
//   wdataIn, labelIn             store data, head tag
//   requireAC, isLastState       queue handshake (idle / head pops next edge)
//   memEN, memWE, memAddr,
//   memWData, memRData           data memory interface
//   cdbReq, cdbGrant,
//   cdbLabel, cdbData            CDB request/grant and broadcast payload
module mem_issue_sequencer
    import mem_issue_sequencer_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 3,
    parameter int unsigned LABEL_W    = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               require,
    input  logic               opIn,
    input  logic [DATA_W-1:0]  addrBase,
    input  logic [DATA_W-1:0]  addrOff,
    input  logic [DATA_W-1:0]  wdataIn,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               requireAC,
    output logic               isLastState,
    output logic               memEN,
    output logic               memWE,
    output logic [DATA_W-1:0]  memAddr,
    output logic [DATA_W-1:0]  memWData,
    input  logic [DATA_W-1:0]  memRData,
    output logic               cdbReq,
    input  logic               cdbGrant,
    output logic [LABEL_W-1:0] cdbLabel,
    output logic [DATA_W-1:0]  cdbData
);

    seq_state_e         state_q, state_d;
    logic               op_q, op_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    logic in_idle;
    logic in_access;
    logic in_wb;

    // Access latency counter; zero marks the final ACCESS cycle.
    mem_latency_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (nRST),
        .load_i     (cnt_load),
        .load_val_i (acc_preload(ACC_CYCLES)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state and latch logic; require is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        label_d  = label_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (require) begin
                    op_d     = opIn;
                    label_d  = labelIn;
                    wdata_d  = wdataIn;
                    addr_d   = addrBase + addrOff;
                    cnt_load = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    if (op_q == OP_LOAD) begin
                        rdata_d = memRData;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                if (cdbGrant) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_STORE;
            label_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            label_q <= label_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_wb     = (state_q == ST_WB);

    // Outputs decode straight from registers so reset clears them at once.
    assign requireAC = in_idle;
    assign memEN     = in_access;
    assign memWE     = in_access && (op_q == OP_STORE);
    assign memAddr   = in_access ? addr_q  : '0;
    assign memWData  = in_access ? wdata_q : '0;
    assign cdbReq    = in_wb;
    assign cdbLabel  = in_wb ? label_q : LABEL_W'(LABEL_NONE);
    assign cdbData   = in_wb ? rdata_q : '0;

    // Pop strobe: last store access cycle, or the granted WB cycle.
    assign isLastState = (in_access && cnt_zero && (op_q == OP_STORE))
                       || (in_wb && cdbGrant);

endmodule

// File: tb/tb_mem_issue_sequencer.sv
// Directed bench for mem_issue_sequencer: one instance with ACC_CYCLES = 3
// and one with ACC_CYCLES = 1, sharing stimulus.
module tb_mem_issue_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    logic          require, opIn, cdbGrant;
    logic [DW-1:0] addrBase, addrOff, wdataIn, memRData;
    logic [LW-1:0] labelIn;

    logic          a_requireAC, a_isLastState, a_memEN, a_memWE, a_cdbReq;
    logic [DW-1:0] a_memAddr, a_memWData, a_cdbData;
    logic [LW-1:0] a_cdbLabel;
    logic          b_requireAC, b_isLastState, b_memEN, b_memWE, b_cdbReq;
    logic [DW-1:0] b_memAddr, b_memWData, b_cdbData;
    logic [LW-1:0] b_cdbLabel;

    mem_issue_sequencer #(.ACC_CYCLES(3), .LABEL_W(LW), .DATA_W(DW)) u_dut_a (
        .clk(clk), .nRST(nRST), .require(require), .opIn(opIn),
        .addrBase(addrBase), .addrOff(addrOff), .wdataIn(wdataIn), .labelIn(labelIn),
        .requireAC(a_requireAC), .isLastState(a_isLastState),
        .memEN(a_memEN), .memWE(a_memWE), .memAddr(a_memAddr), .memWData(a_memWData),
        .memRData(memRData), .cdbReq(a_cdbReq), .cdbGrant(cdbGrant),
        .cdbLabel(a_cdbLabel), .cdbData(a_cdbData)
    );

    mem_issue_sequencer #(.ACC_CYCLES(1), .LABEL_W(LW), .DATA_W(DW)) u_dut_b (
        .clk(clk), .nRST(nRST), .require(require), .opIn(opIn),
        .addrBase(addrBase), .addrOff(addrOff), .wdataIn(wdataIn), .labelIn(labelIn),
        .requireAC(b_requireAC), .isLastState(b_isLastState),
        .memEN(b_memEN), .memWE(b_memWE), .memAddr(b_memAddr), .memWData(b_memWData),
        .memRData(memRData), .cdbReq(b_cdbReq), .cdbGrant(cdbGrant),
        .cdbLabel(b_cdbLabel), .cdbData(b_cdbData)
    );

    typedef struct packed {
        logic          req_ac;
        logic          last;
        logic          en;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          cdb_req;
        logic [LW-1:0] label;
        logic [DW-1:0] data;
    } outs_t;

    typedef struct {
        logic          req;
        logic          op;
        logic [DW-1:0] base;
        logic [DW-1:0] off;
        logic [DW-1:0] wdata;
        logic [LW-1:0] label;
        logic [DW-1:0] rdata;
        logic          grant;
        outs_t         exp;
    } vec_t;

    outs_t a_o, b_o;
    assign a_o = {a_requireAC, a_isLastState, a_memEN, a_memWE, a_memAddr, a_memWData,
                  a_cdbReq, a_cdbLabel, a_cdbData};
    assign b_o = {b_requireAC, b_isLastState, b_memEN, b_memWE, b_memAddr, b_memWData,
                  b_cdbReq, b_cdbLabel, b_cdbData};

    int errors = 0;
    int checks = 0;

    function automatic outs_t eo(input logic rac, input logic lst, input logic en,
                                 input logic we, input logic [DW-1:0] addr,
                                 input logic [DW-1:0] wd, input logic cr,
                                 input logic [LW-1:0] lb, input logic [DW-1:0] dt);
        outs_t o;
        o.req_ac = rac; o.last = lst; o.en = en; o.we = we; o.addr = addr;
        o.wdata = wd; o.cdb_req = cr; o.label = lb; o.data = dt;
        return o;
    endfunction

    function automatic vec_t mk(input logic req, input logic op, input logic [DW-1:0] base,
                                input logic [DW-1:0] off, input logic [DW-1:0] wdata,
                                input logic [LW-1:0] label, input logic [DW-1:0] rdata,
                                input logic grant, input outs_t exp);
        vec_t v;
        v.req = req; v.op = op; v.base = base; v.off = off; v.wdata = wdata;
        v.label = label; v.rdata = rdata; v.grant = grant; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got rac=%b last=%b en=%b we=%b addr=%h wd=%h req=%b lbl=%h dat=%h | exp rac=%b last=%b en=%b we=%b addr=%h wd=%h req=%b lbl=%h dat=%h",
                     name, idx, got.req_ac, got.last, got.en, got.we, got.addr, got.wdata,
                     got.cdb_req, got.label, got.data, exp.req_ac, exp.last, exp.en, exp.we,
                     exp.addr, exp.wdata, exp.cdb_req, exp.label, exp.data);
        end
    endtask

    task automatic drive(input vec_t v);
        require  = v.req;   opIn    = v.op;    addrBase = v.base; addrOff = v.off;
        wdataIn  = v.wdata; labelIn = v.label; memRData = v.rdata; cdbGrant = v.grant;
    endtask

    // Drive after the falling edge, compare 1 time unit later.
    task automatic run_vec(input vec_t v, input bit use_b, input string name, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        check(name, idx, use_b ? b_o : a_o, v.exp);
    endtask

    vec_t  tab_a[20];
    vec_t  tab_b[7];
    vec_t  zero_v;
    outs_t idl;

    initial begin
        idl    = eo(1, 0, 0, 0, 0, 0, 0, 0, 0);
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, idl);

        // ACC_CYCLES = 3: store, stalled load, wrapped-address store.
        tab_a[0]  = mk(1, 0, 32'h100, 32'h24, 32'hDEADBEEF, 4'h0, 0, 0, idl);
        tab_a[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 1, 32'h124, 32'hDEADBEEF, 0, 0, 0));
        tab_a[2]  = mk(1, 1, 0, 0, 0, 0, 0, 1, eo(0, 0, 1, 1, 32'h124, 32'hDEADBEEF, 0, 0, 0));
        tab_a[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 1, 1, 1, 32'h124, 32'hDEADBEEF, 0, 0, 0));
        tab_a[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, idl);
        tab_a[5]  = mk(1, 1, 32'h40, 0, 0, 4'b1100, 0, 0, idl);
        tab_a[6]  = mk(0, 0, 0, 0, 32'h77, 0, 32'h0BAD, 1, eo(0, 0, 1, 0, 32'h40, 0, 0, 0, 0));
        tab_a[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0BAD, 0, eo(0, 0, 1, 0, 32'h40, 0, 0, 0, 0));
        tab_a[8]  = mk(0, 0, 0, 0, 0, 0, 32'h12345678, 0, eo(0, 0, 1, 0, 32'h40, 0, 0, 0, 0));
        for (int i = 9; i <= 12; i++) begin
            tab_a[i] = mk(0, 0, 0, 0, 0, 0, 32'hFFFF, 0,
                          eo(0, 0, 0, 0, 0, 0, 1, 4'b1100, 32'h12345678));
        end
        tab_a[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, eo(0, 1, 0, 0, 0, 0, 1, 4'b1100, 32'h12345678));
        tab_a[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, idl);
        tab_a[15] = mk(1, 0, 32'hFFFFFFFC, 32'h8, 32'h5A5A5A5A, 4'h3, 0, 0, idl);
        tab_a[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 1, 32'h4, 32'h5A5A5A5A, 0, 0, 0));
        tab_a[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 1, 32'h4, 32'h5A5A5A5A, 0, 0, 0));
        tab_a[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 1, 1, 1, 32'h4, 32'h5A5A5A5A, 0, 0, 0));
        tab_a[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, idl);

        // ACC_CYCLES = 1: back-to-back store then load, require toggled in ACCESS.
        tab_b[0] = mk(1, 0, 32'h200, 0, 32'h11, 0, 0, 0, idl);
        tab_b[1] = mk(1, 1, 32'h300, 0, 0, 4'h5, 0, 0, eo(0, 1, 1, 1, 32'h200, 32'h11, 0, 0, 0));
        tab_b[2] = mk(1, 1, 32'h300, 0, 0, 4'h5, 0, 0, idl);
        tab_b[3] = mk(0, 0, 0, 0, 32'h99, 0, 32'hCAFEF00D, 1, eo(0, 0, 1, 0, 32'h300, 0, 0, 0, 0));
        tab_b[4] = mk(1, 0, 0, 0, 0, 0, 0, 1, eo(0, 1, 0, 0, 0, 0, 1, 4'h5, 32'hCAFEF00D));
        tab_b[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, idl);
        tab_b[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, idl);

        // Reset, then 10 idle cycles with require low.
        nRST = 1'b0;
        drive(zero_v);
        repeat (3) @(negedge clk);
        #1;
        check("in_reset", 0, a_o, idl);
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_vec(zero_v, 1'b0, "idle", i);
        end

        for (int i = 0; i < 20; i++) begin
            run_vec(tab_a[i], 1'b0, "tab_a", i);
        end

        // Reset asserted during the second ACCESS cycle of a store.
        run_vec(mk(1, 0, 32'h10, 32'h20, 32'h1, 0, 0, 0, idl), 1'b0, "rst_issue", 0);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 1, 32'h30, 32'h1, 0, 0, 0)),
                1'b0, "rst_acc", 1);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 1, 32'h30, 32'h1, 0, 0, 0)),
                1'b0, "rst_acc", 2);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_async", 0, a_o, idl);
        for (int i = 0; i < 2; i++) begin
            run_vec(zero_v, 1'b0, "rst_hold", i);
        end
        @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_vec(zero_v, 1'b0, "rst_after", i);
        end

        for (int i = 0; i < 7; i++) begin
            run_vec(tab_b[i], 1'b1, "tab_b", i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_issue_sequencer.md
Name: mem_issue_sequencer

Overview:
- Sequences the head entry of the load/store issue queue into the multi-cycle data memory.
- Returns the queue handshake: `requireAC` (memory available) and `isLastState` (head may pop next edge).
- Arbitrates load results onto the common data bus (CDB) through a request/grant pair.
- Sits between the store/load queue, the data memory array and the CDB arbiter; replaces the ad-hoc control inside the memory wrapper.

Parameters:
- ACC_CYCLES, 3, memory access latency in cycles; legal range 1..15.
- LABEL_W, 4, width of reservation-station/queue labels.
- DATA_W, 32, data and address width.

Ports:
- clk  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- require  in  1  queue head valid and operands ready
- opIn  in  1  head op; 1 = load (read), 0 = store (write)
- addrBase  in  DATA_W  address operand 1
- addrOff  in  DATA_W  address operand 2
- wdataIn  in  DATA_W  store data
- labelIn  in  LABEL_W  head IdLabel, broadcast tag for loads
- requireAC  out  1  sequencer idle; head may issue this cycle
- isLastState  out  1  head op completes this cycle; queue pops on next edge
- memEN  out  1  memory enable
- memWE  out  1  memory write enable
- memAddr  out  DATA_W  byte address to memory
- memWData  out  DATA_W  write data to memory
- memRData  in  DATA_W  read data, valid on last access cycle
- cdbReq  out  1  request CDB slot for load result
- cdbGrant  in  1  CDB arbiter grant, same-cycle response
- cdbLabel  out  LABEL_W  broadcast tag
- cdbData  out  DATA_W  broadcast value

Behaviour:
- Reset values: state = IDLE and all registers 0.
  - Outputs in reset: `requireAC` = 1; all other outputs 0.
- Reset is asynchronous. Asserting it mid-access aborts the operation.
  - `memWE`/`memEN` drop immediately.
  - No CDB request is made and no `isLastState` is produced.
- The FSM has three states: IDLE, ACCESS and WB.
- IDLE:
  - `requireAC` = 1.
  - If `require` = 1 at the clock edge, latch `opIn`, `labelIn` and `wdataIn`, plus `addr` = `addrBase` + `addrOff` (mod 2^DATA_W, carry dropped).
  - Load `cnt` = ACC_CYCLES-1 and go to ACCESS.
  - If `require` = 0, stay in IDLE.
  - `require` is sampled only in IDLE; changes on `require` in other states are ignored.
- ACCESS:
  - `requireAC` = 0 and `memEN` = 1.
  - `memAddr` = latched `addr`; `memWData` = latched data; `memWE` = !latched op.
  - All three memory outputs stay stable for the whole state.
  - `cnt` decrements each cycle. The last cycle is `cnt` == 0.
  - Store, last cycle: `isLastState` = 1 (combinational); next state IDLE.
  - Load, last cycle: capture `memRData` into `rdata`; next state WB.
  - ACC_CYCLES = 1 gives a single ACCESS cycle.
- WB (loads only):
  - `cdbReq` = 1, `cdbLabel` = latched label, `cdbData` = `rdata`; `memEN` = 0.
  - When `cdbGrant` = 1: `isLastState` = 1 in that same cycle, next state IDLE.
  - Otherwise hold WB with all outputs stable. There is no timeout.
- `cdbGrant` outside WB is ignored.
- `isLastState` is high for exactly one cycle per issued op, and never in IDLE.
- Latency, issue edge to `isLastState`:
  - Store: ACC_CYCLES cycles.
  - Load: ACC_CYCLES + 1 + grant-wait cycles.
- Throughput: there is one idle bubble between operations. The queue sees `requireAC` = 1 in the cycle after its pop.
- `memAddr`, `memWData` and `memWE` are 0 outside ACCESS; `cdbLabel` and `cdbData` are 0 outside WB.

Decomposition:
- Shared header (alongside the existing label macros):
  - FSM state encodings: IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2.
  - Op encodings: OP_LOAD = 1, OP_STORE = 0.
  - Queue label constants reused for `cdbLabel`.
- Sub-module: `mem_latency_counter`, a loadable down-counter with a `zero` flag. It is natural and reusable by other multi-cycle units. Everything else stays flat.

Test Plan:
- Reset then idle: hold nRST low, release with `require` = 0 → `requireAC` = 1, `memEN` = 0, `cdbReq` = 0, `isLastState` = 0 for 10 cycles.
- Store: ACC_CYCLES = 3, `require` = 1, op = 0, base = 0x100, off = 0x24, data = 0xDEADBEEF.
  - `memWE`/`memEN` high for exactly 3 cycles with `memAddr` = 0x124.
  - `isLastState` high in the 3rd cycle; `requireAC` high the cycle after.
- Load with grant stall: op = 1, addr = 0x40, memory returns 0x12345678, label = 4'b1100, grant withheld 4 cycles.
  - `cdbReq` held 5 cycles with data 0x12345678 and label 4'b1100.
  - `isLastState` high only in the grant cycle.
- Address wrap: base = 0xFFFFFFFC, off = 0x8 → `memAddr` = 0x00000004.
- Reset mid-ACCESS on cycle 2 of a store → `memWE` drops asynchronously; no `isLastState`; IDLE after release.
- Back-to-back ops with ACC_CYCLES = 1 and `require` held high:
  - Store then load.
  - Each `isLastState` is followed by exactly one IDLE cycle before the next issue.
  - `require` toggling during ACCESS has no effect.
